// File: rtl/seq_mult_signed.sv
// seq_mult_signed: early-terminating shift-add multiplier, signed or unsigned, start/busy/done handshake
module seq_mult_signed #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mp,
  input  logic [WIDTH-1:0]   mc,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               neg
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [WIDTH-1:0] mpr, mp_mag, mc_mag;
  logic [2*WIDTH-1:0] mcd, acc, res;
  logic s;
  always_comb begin
    mp_mag = (SIGNED && mp[WIDTH-1]) ? -mp : mp;
    mc_mag = (SIGNED && mc[WIDTH-1]) ? -mc : mc;
    res = s ? -acc : acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      neg <= 1'b0;
      mpr <= '0;
      mcd <= '0;
      acc <= '0;
      s <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mpr <= mp_mag;
          mcd <= {{WIDTH{1'b0}}, mc_mag};
          s <= SIGNED && (mp[WIDTH-1] ^ mc[WIDTH-1]);
          acc <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: if (mpr == '0) state <= FIN;
        else begin
          if (mpr[0]) acc <= acc + mcd;
          mcd <= mcd << 1;
          mpr <= mpr >> 1;
          if (mpr[WIDTH-1:1] == '0) state <= FIN;
        end
        FIN: begin
          product <= res;
          neg <= SIGNED && res[2*WIDTH-1];
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_signed.sv
// tb_seq_mult_signed: directed table and handshake checks on 8-bit signed, 8-bit unsigned and 16-bit signed multipliers
module tb_seq_mult_signed;
  logic clk = 1'b0, rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [7:0] mp0 = '0, mc0 = '0, mp1 = '0, mc1 = '0;
  logic [15:0] mp2 = '0, mc2 = '0;
  logic busy0, busy1, busy2, done0, done1, done2, neg0, neg1, neg2;
  logic [15:0] prod0, prod1;
  logic [31:0] prod2;
  int cur = 0, n_chk = 0, n_fail = 0;
  logic sd, sb, sn;
  logic [31:0] sp;
  always #5 clk = ~clk;
  seq_mult_signed #(.WIDTH(8), .SIGNED(1'b1)) u0 (.clk(clk), .rst(rst), .start(start0), .mp(mp0), .mc(mc0),
    .busy(busy0), .done(done0), .product(prod0), .neg(neg0));
  seq_mult_signed #(.WIDTH(8), .SIGNED(1'b0)) u1 (.clk(clk), .rst(rst), .start(start1), .mp(mp1), .mc(mc1),
    .busy(busy1), .done(done1), .product(prod1), .neg(neg1));
  seq_mult_signed #(.WIDTH(16), .SIGNED(1'b1)) u2 (.clk(clk), .rst(rst), .start(start2), .mp(mp2), .mc(mc2),
    .busy(busy2), .done(done2), .product(prod2), .neg(neg2));
  always_comb begin
    sd = cur == 0 ? done0 : cur == 1 ? done1 : done2;
    sb = cur == 0 ? busy0 : cur == 1 ? busy1 : busy2;
    sn = cur == 0 ? neg0 : cur == 1 ? neg1 : neg2;
    sp = cur == 0 ? {16'h0, prod0} : cur == 1 ? {16'h0, prod1} : prod2;
  end
  typedef struct {
    logic [7:0] mp;
    logic [7:0] mc;
    int lat;
    logic [15:0] prod;
    logic neg;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (w == 0) begin start0 = st; mp0 = a[7:0]; mc0 = b[7:0]; end
    else if (w == 1) begin start1 = st; mp1 = a[7:0]; mc1 = b[7:0]; end
    else begin start2 = st; mp2 = a; mc2 = b; end
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (sd) begin lat = e; break; end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_low_in_done", {31'h0, sb}, 32'd0);
  endtask
  task automatic run(input int w, input logic [15:0] a, input logic [15:0] b,
                     output int lat, output logic [31:0] p, output logic n);
    cur = w;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, a, b);
    chk("busy_after_accept", {31'h0, sb}, 32'd1);
    wait_done(lat);
    p = sp;
    n = sn;
  endtask
  initial begin
    int lat, cnt;
    logic [31:0] p;
    logic n;
    v[0] = '{8'hF9, 8'd13, 4, 16'hFFA5, 1'b1};
    v[1] = '{8'h80, 8'h80, 9, 16'h4000, 1'b0};
    v[2] = '{8'h01, 8'h80, 2, 16'hFF80, 1'b1};
    v[3] = '{8'h00, 8'hFB, 2, 16'h0000, 1'b0};
    v[4] = '{8'h05, 8'h00, 4, 16'h0000, 1'b0};
    v[5] = '{8'h03, 8'h04, 3, 16'h000C, 1'b0};
    v[6] = '{8'hFF, 8'hFF, 2, 16'h0001, 1'b0};
    v[7] = '{8'h7F, 8'h81, 8, 16'hC0FF, 1'b1};
    v[8] = '{8'h80, 8'h7F, 9, 16'hC080, 1'b1};
    v[9] = '{8'h02, 8'hFD, 3, 16'hFFFA, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {29'h0, busy0, busy1, busy2}, 32'd0);
    chk("reset_done", {29'h0, done0, done1, done2}, 32'd0);
    chk("reset_prod", {prod0 | prod1, 16'h0} | prod2, 32'd0);
    chk("reset_neg", {29'h0, neg0, neg1, neg2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run(0, {8'h0, v[i].mp}, {8'h0, v[i].mc}, lat, p, n);
      chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
      chk($sformatf("vec%0d_prod", i), p, {16'h0, v[i].prod});
      chk($sformatf("vec%0d_neg", i), {31'h0, n}, {31'h0, v[i].neg});
    end
    run(1, 16'hFF, 16'hFF, lat, p, n);
    chk("u8_ff_lat", lat, 9);
    chk("u8_ff_prod", p, 32'h0000FE01);
    chk("u8_ff_neg", {31'h0, n}, 32'd0);
    run(1, 16'h03, 16'h05, lat, p, n);
    chk("u8_3x5_lat", lat, 3);
    chk("u8_3x5_prod", p, 32'h0000000F);
    run(2, 16'h8000, 16'h7FFF, lat, p, n);
    chk("s16_lat", lat, 17);
    chk("s16_prod", p, 32'hC0008000);
    chk("s16_neg", {31'h0, n}, 32'd1);
    cur = 0;
    @(negedge clk);
    drive(0, 1'b1, 16'h80, 16'h02);
    @(negedge clk);
    drive(0, 1'b0, 16'h80, 16'h02);
    @(negedge clk);
    drive(0, 1'b1, 16'h01, 16'h01);
    @(negedge clk);
    drive(0, 1'b0, 16'h01, 16'h01);
    @(posedge clk); #1;
    wait_done(lat);
    chk("ignore_start_lat", lat + 3, 9);
    chk("ignore_start_prod", sp, 32'h0000FF00);
    @(negedge clk);
    drive(0, 1'b1, 16'h02, 16'h05);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h03, 16'h04);
    wait_done(lat);
    chk("held_first_lat", lat, 3);
    chk("held_first_prod", sp, 32'h0000000A);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h03, 16'h04);
    chk("held_accept_busy", {31'h0, sb}, 32'd1);
    wait_done(lat);
    chk("held_second_lat", lat, 3);
    chk("held_second_prod", sp, 32'h0000000C);
    @(negedge clk);
    drive(0, 1'b1, 16'h80, 16'h03);
    @(negedge clk);
    drive(0, 1'b0, 16'h80, 16'h03);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'h0, busy0}, 32'd0);
    chk("abort_done", {31'h0, done0}, 32'd0);
    chk("abort_prod", {16'h0, prod0}, 32'd0);
    chk("abort_neg", {31'h0, neg0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done0 || busy0) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
